// File: rtl/arith_arbiter_if.sv
// Shared operand/opcode types and the request/response bundle between
// the two requesters, the arbiter and the response consumer.
package arith_pkg;
   typedef logic [63:0] ulong_t;

   typedef enum logic [3:0] {
      ADD  = 4'd0,
      SUB  = 4'd1,
      MUL  = 4'd2,
      UDIV = 4'd3,
      UMOD = 4'd4,
      SDIV = 4'd5,
      SMOD = 4'd6,
      INC  = 4'd7,
      DEC  = 4'd8
   } opcode_t;

   function automatic logic is_div(input opcode_t op);
      return op inside {UDIV, UMOD, SDIV, SMOD};
   endfunction
endpackage

interface arith_arbiter_if;
   import arith_pkg::*;

   logic    req0Valid;
   logic    req0Ready;
   opcode_t req0Op;
   ulong_t  req0A;
   ulong_t  req0B;
   logic    req0CarryIn;

   logic    req1Valid;
   logic    req1Ready;
   opcode_t req1Op;
   ulong_t  req1A;
   ulong_t  req1B;
   logic    req1CarryIn;

   logic    respValid;
   logic    respReady;
   logic    respId;
   ulong_t  respResult;
   logic    respCarry;
   logic    respDivByZero;

   modport slave (
      input  req0Valid, req0Op, req0A, req0B, req0CarryIn,
      input  req1Valid, req1Op, req1A, req1B, req1CarryIn,
      input  respReady,
      output req0Ready, req1Ready,
      output respValid, respId, respResult, respCarry, respDivByZero
   );

   modport master (
      output req0Valid, req0Op, req0A, req0B, req0CarryIn,
      output req1Valid, req1Op, req1A, req1B, req1CarryIn,
      output respReady,
      input  req0Ready, req1Ready,
      input  respValid, respId, respResult, respCarry, respDivByZero
   );
endinterface

// File: rtl/arith_arbiter.sv
// Two-requester arbiter in front of a single shared 64-bit arithmetic unit.
// Define ARITH_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority to requester 0.
module arithmetic
   import arith_pkg::*;
(
   input  opcode_t     i_op,
   input  ulong_t      i_a,
   input  ulong_t      i_b,
   input  logic        i_carry_in,
   output logic [64:0] o_sum,
   output logic        o_div_by_zero
);
   logic [64:0]        w_prod;
   logic signed [63:0] w_sdiv;
   logic signed [63:0] w_smod;

   assign w_prod = 65'(i_a) * 65'(i_b);
   assign w_sdiv = $signed(i_a) / $signed(i_b);
   assign w_smod = $signed(i_a) % $signed(i_b);

   always_comb begin
      o_sum         = '0;
      o_div_by_zero = 1'b0;
      if (is_div(i_op) && (i_b == '0)) begin
         o_div_by_zero = 1'b1;
      end else begin
         case (i_op)
            ADD:     o_sum = 65'(i_a) + 65'(i_b) + 65'(i_carry_in);
            SUB:     o_sum = 65'(i_a) - 65'(i_b) - 65'(i_carry_in);
            MUL:     o_sum = w_prod;
            UDIV:    o_sum = {1'b0, i_a / i_b};
            UMOD:    o_sum = {1'b0, i_a % i_b};
            SDIV:    o_sum = {1'b0, w_sdiv};
            SMOD:    o_sum = {1'b0, w_smod};
            INC:     o_sum = 65'(i_a) + 65'd1;
            DEC:     o_sum = 65'(i_a) - 65'd1;
            default: o_sum = '0;
         endcase
      end
   end
endmodule

// state | meaning
// IDLE  | waiting for a request; only state that grants
// EXEC  | operands captured, arithmetic settling (1 or DIV_CYCLES cycles)
// RESP  | response registered, held until respReady
module arith_arbiter
   import arith_pkg::*;
#(
   parameter int unsigned DIV_CYCLES = 8
) (
   input  logic           clk,
   input  logic           resetN,
   arith_arbiter_if.slave bus
);
   localparam logic [6:0] CNT_LOAD = 7'(DIV_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [6:0]  r_cnt;
   opcode_t     r_op;
   ulong_t      r_a;
   ulong_t      r_b;
   logic        r_carry_in;
   logic        r_id;
   logic        r_resp_valid;
   logic        r_resp_id;
   ulong_t      r_resp_result;
   logic        r_resp_carry;
   logic        r_resp_dbz;

   logic        w_grant1;
   logic        w_idle;
   logic        w_accept;
   opcode_t     w_sel_op;
   ulong_t      w_sel_b;
   logic [64:0] w_sum;
   logic        w_dbz;
   logic        w_exec_done;

`ifdef ARITH_ARB_ROUND_ROBIN_EN
   logic        r_last_grant;
   assign w_grant1 = bus.req1Valid && (!bus.req0Valid || !r_last_grant);
`else
   assign w_grant1 = bus.req1Valid && !bus.req0Valid;
`endif

   assign w_idle        = (r_state == S_IDLE) && resetN;
   assign bus.req0Ready = w_idle && bus.req0Valid && !w_grant1;
   assign bus.req1Ready = w_idle && w_grant1;
   assign w_accept      = bus.req0Ready || bus.req1Ready;
   assign w_sel_op      = w_grant1 ? bus.req1Op : bus.req0Op;
   assign w_sel_b       = w_grant1 ? bus.req1B  : bus.req0B;
   assign w_exec_done   = (r_state == S_EXEC) && (r_cnt == '0);

   arithmetic u_arithmetic (
      .i_op          (r_op),
      .i_a           (r_a),
      .i_b           (r_b),
      .i_carry_in    (r_carry_in),
      .o_sum         (w_sum),
      .o_div_by_zero (w_dbz)
   );

   always_ff @(posedge clk) begin
      if (!resetN) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = S_EXEC;
         S_EXEC:  if (r_cnt == '0) w_state_nxt = S_RESP;
         S_RESP:  if (bus.respReady) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         r_cnt         <= '0;
         r_op          <= ADD;
         r_a           <= '0;
         r_b           <= '0;
         r_carry_in    <= 1'b0;
         r_id          <= 1'b0;
         r_resp_valid  <= 1'b0;
         r_resp_id     <= 1'b0;
         r_resp_result <= '0;
         r_resp_carry  <= 1'b0;
         r_resp_dbz    <= 1'b0;
`ifdef ARITH_ARB_ROUND_ROBIN_EN
         r_last_grant  <= 1'b1;
`endif
      end else begin
         if (w_accept) begin
            r_op       <= w_sel_op;
            r_a        <= w_grant1 ? bus.req1A : bus.req0A;
            r_b        <= w_sel_b;
            r_carry_in <= w_grant1 ? bus.req1CarryIn : bus.req0CarryIn;
            r_id       <= w_grant1;
            // only a real divide gets the long settle window
            r_cnt      <= (is_div(w_sel_op) && (w_sel_b != '0)) ? CNT_LOAD : '0;
`ifdef ARITH_ARB_ROUND_ROBIN_EN
            r_last_grant <= w_grant1;
`endif
         end else if ((r_state == S_EXEC) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 7'd1;
         end

         if (w_exec_done) begin
            r_resp_valid  <= 1'b1;
            r_resp_id     <= r_id;
            r_resp_result <= w_sum[63:0];
            r_resp_carry  <= w_sum[64];
            r_resp_dbz    <= w_dbz;
         end else if ((r_state == S_RESP) && bus.respReady) begin
            r_resp_valid  <= 1'b0;
         end
      end
   end

   assign bus.respValid     = r_resp_valid;
   assign bus.respId        = r_resp_id;
   assign bus.respResult    = r_resp_result;
   assign bus.respCarry     = r_resp_carry;
   assign bus.respDivByZero = r_resp_dbz;
endmodule

// File: tb/tb_arith_arbiter.sv
// Bench for arith_arbiter: directed cases plus randomized ops against a
// behavioural model of results, latency and grant order.
module tb_arith_arbiter;
   import arith_pkg::*;

   localparam int DIVC = 8;

   logic clk = 1'b0;
   logic resetN;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   arith_arbiter_if bus ();

   arith_arbiter #(.DIV_CYCLES(DIVC)) dut (
      .clk    (clk),
      .resetN (resetN),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // {divByZero, carry, result[63:0]}
   function automatic logic [65:0] model(opcode_t op, ulong_t a, ulong_t b, logic cin);
      logic [64:0]  s;
      logic         dbz;
      logic [127:0] p;
      longint       sa, sb;
      s = '0; dbz = 1'b0; sa = a; sb = b;
      case (op)
         ADD: s = 65'(a) + 65'(b) + 65'(cin);
         SUB: s = 65'(a) - 65'(b) - 65'(cin);
         MUL: begin p = 128'(a) * 128'(b); s = p[64:0]; end
         UDIV, UMOD, SDIV, SMOD: begin
            if (b == 0) dbz = 1'b1;
            else if (op == UDIV) s = {1'b0, a / b};
            else if (op == UMOD) s = {1'b0, a % b};
            else if (op == SDIV) s = {1'b0, 64'(sa / sb)};
            else                 s = {1'b0, 64'(sa % sb)};
         end
         INC: s = 65'(a) + 65'd1;
         DEC: s = 65'(a) - 65'd1;
         default: s = '0;
      endcase
      return {dbz, s};
   endfunction

   function automatic int exp_lat(opcode_t op, ulong_t b);
      if ((op == UDIV || op == UMOD || op == SDIV || op == SMOD) && b != 0) return DIVC + 1;
      return 2;
   endfunction

   task automatic set_req(input int id, input logic v, input opcode_t op,
                          input ulong_t a, input ulong_t b, input logic cin);
      if (id == 0) begin
         bus.req0Valid = v; bus.req0Op = op; bus.req0A = a; bus.req0B = b; bus.req0CarryIn = cin;
      end else begin
         bus.req1Valid = v; bus.req1Op = op; bus.req1A = a; bus.req1B = b; bus.req1CarryIn = cin;
      end
   endtask

   function automatic logic rdy_of(int id);
      return (id == 0) ? bus.req0Ready : bus.req1Ready;
   endfunction

   // one full transaction with respReady=1; returns the observed result
   task automatic do_op(input int id, input opcode_t op, input ulong_t a, input ulong_t b,
                        input logic cin, input string tag, output ulong_t res);
      logic [65:0] e;
      int t0, n;
      e = model(op, a, b, cin);
      set_req(id, 1'b1, op, a, b, cin);
      #1;
      n = 0;
      while (rdy_of(id) !== 1'b1 && n < 20) begin tick(); n++; end
      chk({tag, " ready"}, 64'(rdy_of(id)), 64'd1);
      t0 = cyc;
      tick();
      set_req(id, 1'b0, op, a, b, cin);
      n = 0;
      while (bus.respValid !== 1'b1 && n < 100) begin tick(); n++; end
      chk({tag, " latency"}, 64'(cyc - t0), 64'(exp_lat(op, b)));
      chk({tag, " result"}, bus.respResult, e[63:0]);
      chk({tag, " carry"}, 64'(bus.respCarry), 64'(e[64]));
      chk({tag, " dbz"}, 64'(bus.respDivByZero), 64'(e[65]));
      chk({tag, " id"}, 64'(bus.respId), 64'(id));
      res = bus.respResult;
      tick();
   endtask

   initial begin
      ulong_t res, hold_res;
      logic   hold_c, hold_d;
      int     n, seen;
      logic   rr;
`ifdef ARITH_ARB_ROUND_ROBIN_EN
      rr = 1'b1;
`else
      rr = 1'b0;
`endif
      resetN = 1'b0;
      bus.respReady = 1'b1;
      set_req(0, 1'b1, ADD, 1, 2, 0);
      set_req(1, 1'b1, ADD, 3, 4, 0);
      tick(); tick();
      chk("rst ready0", 64'(bus.req0Ready), 0);
      chk("rst ready1", 64'(bus.req1Ready), 0);
      chk("rst respValid", 64'(bus.respValid), 0);
      chk("rst respResult", bus.respResult, 0);
      chk("rst respId", 64'(bus.respId), 0);
      set_req(0, 1'b0, ADD, 0, 0, 0);
      set_req(1, 1'b0, ADD, 0, 0, 0);
      resetN = 1'b1;
      tick();

      do_op(0, ADD, 5, 7, 1'b1, "add", res);
      chk("add const", res, 64'd13);
      do_op(1, UDIV, 100, 7, 1'b0, "udiv", res);
      chk("udiv const", res, 64'd14);
      do_op(1, UMOD, 100, 7, 1'b0, "umod", res);
      chk("umod const", res, 64'd2);
      do_op(0, SDIV, -64'sd9, 0, 1'b0, "sdiv0", res);
      chk("sdiv0 const", res, 64'd0);
      do_op(0, SDIV, -64'sd9, 2, 1'b0, "sdivneg", res);
      do_op(1, SMOD, -64'sd9, 2, 1'b0, "smodneg", res);
      do_op(0, SUB, 3, 5, 1'b1, "subborrow", res);
      do_op(0, DEC, 0, 0, 1'b0, "decwrap", res);
      do_op(1, ADD, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0, "addcarry", res);
      do_op(0, opcode_t'(4'd12), 99, 99, 1'b1, "illegal", res);

      // back-pressure in RESP with a second request waiting
      bus.respReady = 1'b0;
      set_req(0, 1'b1, MUL, 64'h1_0000_0001, 64'h3, 1'b0);
      #1;
      chk("stall ready0", 64'(bus.req0Ready), 1);
      tick();
      set_req(0, 1'b0, MUL, 0, 0, 0);
      set_req(1, 1'b1, INC, 41, 0, 1'b0);
      n = 0;
      while (bus.respValid !== 1'b1 && n < 20) begin tick(); n++; end
      hold_res = bus.respResult; hold_c = bus.respCarry; hold_d = bus.respDivByZero;
      chk("stall first", hold_res, 64'h3_0000_0003);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("stall valid", 64'(bus.respValid), 1);
         chk("stall result", bus.respResult, hold_res);
         chk("stall carry", 64'(bus.respCarry), 64'(hold_c));
         chk("stall dbz", 64'(bus.respDivByZero), 64'(hold_d));
         chk("stall rdy0", 64'(bus.req0Ready), 0);
         chk("stall rdy1", 64'(bus.req1Ready), 0);
      end
      bus.respReady = 1'b1;
      tick();
      chk("pending rdy1", 64'(bus.req1Ready), 1);
      tick();
      set_req(1, 1'b0, INC, 0, 0, 0);
      n = 0;
      while (bus.respValid !== 1'b1 && n < 20) begin tick(); n++; end
      chk("pending result", bus.respResult, 64'd42);
      chk("pending id", 64'(bus.respId), 1);
      tick();

      // reset in the middle of a divide
      set_req(1, 1'b1, UDIV, 1000, 3, 1'b0);
      tick();
      set_req(1, 1'b0, UDIV, 0, 0, 0);
      tick(); tick();
      resetN = 1'b0;
      set_req(0, 1'b1, ADD, 1, 1, 0);
      #1;
      chk("midrst rdy0", 64'(bus.req0Ready), 0);
      tick();
      resetN = 1'b1;
      set_req(0, 1'b0, ADD, 0, 0, 0);
      #1;
      chk("midrst valid", 64'(bus.respValid), 0);
      set_req(0, 1'b1, ADD, 1, 1, 0);
      #1;
      chk("midrst idle", 64'(bus.req0Ready), 1);
      set_req(0, 1'b0, ADD, 0, 0, 0);
      seen = 0;
      for (int k = 0; k < 12; k++) begin tick(); if (bus.respValid === 1'b1) seen++; end
      chk("midrst noresp", 64'(seen), 0);

      // contention from a fresh reset
      resetN = 1'b0;
      tick();
      resetN = 1'b1;
      set_req(0, 1'b1, ADD, 1, 1, 0);
      set_req(1, 1'b1, ADD, 10, 10, 0);
      for (int k = 0; k < 4; k++) begin
         n = 0;
         while (bus.respValid !== 1'b1 && n < 20) begin tick(); n++; end
         chk("contend id", 64'(bus.respId), rr ? 64'(k % 2) : 64'd0);
         chk("contend result", bus.respResult, (bus.respId === 1'b1) ? 64'd20 : 64'd2);
         tick();
      end
      set_req(0, 1'b0, ADD, 0, 0, 0);
      set_req(1, 1'b0, ADD, 0, 0, 0);
      tick(); tick(); tick();

      for (int k = 0; k < 40; k++) begin
         opcode_t op;
         ulong_t  a, b;
         op = opcode_t'(4'($urandom_range(0, 15)));
         a  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 20)) : {$urandom, $urandom};
         b  = ($urandom_range(0, 4) == 0) ? 64'd0 : {$urandom, $urandom};
         if ($urandom_range(0, 2) == 0) b = 64'($urandom_range(1, 9));
         if ((op == SDIV || op == SMOD) && a == 64'h8000_0000_0000_0000 && b == '1) b = 64'd3;
         do_op(int'($urandom_range(0, 1)), op, a, b, 1'($urandom_range(0, 1)), "rand", res);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
